// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the switch/button debounce slice.
package debounce_pkg;

   localparam int CLK_HZ               = 100_000_000;
   // 10 us prescaler tick and 20 ms settle window at the board clock.
   localparam int DEFAULT_TICK_DIV     = CLK_HZ / 100_000;
   localparam int DEFAULT_STABLE_TICKS = 2000;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   // A divide-by-one prescaler still needs a one-bit register.
   function automatic int presc_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Pin-side levels in, conditioned levels and edge pulses out, one bit per channel.
interface input_debouncer_if #(
   parameter int N = 3
);
   logic [N-1:0] raw_in;
   logic [N-1:0] db_out;
   logic [N-1:0] rise;
   logic [N-1:0] fall;

   modport master (
      output raw_in,
      input  db_out,
      input  rise,
      input  fall
   );

   modport slave (
      input  raw_in,
      output db_out,
      output rise,
      output fall
   );
endinterface

// File: rtl/debounce_channel.sv
// One debounced channel: two-flop synchronizer, tick-counted settle filter,
// accepted level register and single-cycle rise/fall pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter bit RESET_VAL    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_tick,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int             CW       = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;
   logic [CW-1:0] r_cnt;

   logic          w_differ;
   logic          w_accept;
   logic [CW-1:0] w_cnt_nxt;

   // Any agreement wipes progress; the count only advances on ticks and saturates by acceptance.
   always_comb begin
      w_differ  = r_s2 ^ r_level;
      w_accept  = 1'b0;
      w_cnt_nxt = r_cnt;
      if (!w_differ) begin
         w_cnt_nxt = CNT_ZERO;
      end else if (!i_tick) begin
         w_cnt_nxt = r_cnt;
      end else if (r_cnt == CNT_LAST) begin
         w_accept  = 1'b1;
         w_cnt_nxt = CNT_ZERO;
      end else begin
         w_cnt_nxt = r_cnt + CNT_ONE;
      end
   end

   // Synchronizer, filter count, accepted level and registered edge pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1    <= RESET_VAL;
         r_s2    <= RESET_VAL;
         r_level <= RESET_VAL;
         r_cnt   <= CNT_ZERO;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_accept ? r_s2 : r_level;
         r_rise  <= w_accept & r_s2;
         r_fall  <= w_accept & ~r_s2;
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// Board input conditioner: shared tick prescaler driving N independent debounce channels.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int N            = 3,
   parameter int TICK_DIV     = DEFAULT_TICK_DIV,
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter bit RESET_VAL    = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input_debouncer_if.slave   bus
);

   localparam int            PW         = presc_width(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   logic [PW-1:0] r_presc;
   logic          w_tick;
   logic [N-1:0]  w_level;
   logic [N-1:0]  w_rise;
   logic [N-1:0]  w_fall;

   // With TICK_DIV of one the counter sits at zero and every cycle is a tick.
   assign w_tick = (r_presc == PRESC_LAST);

   // Free-running prescaler, wraps after the tick cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= PRESC_ZERO;
      end else if (w_tick) begin
         r_presc <= PRESC_ZERO;
      end else begin
         r_presc <= r_presc + PRESC_ONE;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_chan
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .RESET_VAL    (RESET_VAL)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .i_tick  (w_tick),
         .i_raw   (bus.raw_in[g]),
         .o_level (w_level[g]),
         .o_rise  (w_rise[g]),
         .o_fall  (w_fall[g])
      );
   end

   assign bus.db_out = w_level;
   assign bus.rise   = w_rise;
   assign bus.fall   = w_fall;

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions the raw board switches and pushbutton before they drive the JK flip-flop inputs and its reset.
- Each channel runs through a 2-flop synchronizer, then a debounce filter counted in prescaler ticks.
- Each channel produces a clean level plus single-cycle rise/fall pulses.
- Sits between the top-level pins (sw, btnC) and the jk block, one instance per board.

Parameters:
- N, 3, number of channels (sw[1:0] + btnC).
- TICK_DIV, 1000, clk cycles per debounce tick (10 us at 100 MHz); must be >= 1.
- STABLE_TICKS, 2000, consecutive ticks of disagreement required to accept a new level (20 ms); must be >= 1.
- RESET_VAL, 0, per-design reset level of every channel (applied to all N).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  reset, asynchronous, active-high.
- raw_in  input  N  unsynchronized pin levels.
- db_out  output  N  debounced level.
- rise  output  N  one-cycle pulse when db_out goes 0->1.
- fall  output  N  one-cycle pulse when db_out goes 1->0.

Behaviour:
- Reset (async assert, sync use after deassert):
  - sync flops, db_out and internal state all load RESET_VAL.
  - Counters, prescaler, rise and fall load 0.
  - No pulse is generated on the first cycles after reset release, even if raw_in != RESET_VAL; that difference is debounced normally.
- Synchronizer: two flops per channel (s1, s2); s2 is the filtered input. Latency raw_in -> s2 is 2 clk edges.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1; tick=1 in the cycle the count equals TICK_DIV-1, then wraps to 0.
  - TICK_DIV=1 means tick every cycle.
  - Shared by all channels.
- Per-channel filter, width $clog2(STABLE_TICKS+1), evaluated every clk:
  - s2 == db_out: cnt <= 0 (any agreement, tick or not, clears progress).
  - s2 != db_out, tick=0: cnt holds.
  - s2 != db_out, tick=1, cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - s2 != db_out, tick=1, cnt == STABLE_TICKS-1: db_out <= s2, cnt <= 0, and the matching rise/fall is asserted for exactly that one cycle.
  - cnt never exceeds STABLE_TICKS-1; no wrap.
- rise and fall are registered and are never both high on one channel. Channels are fully independent, so pulses on different channels can coincide.
- Glitch shorter than the interval spanning STABLE_TICKS ticks: no output change, no pulse.
- Bounce pattern: any return to the accepted level restarts the count from 0.
- Reset asserted mid-count: everything returns to reset values immediately; no pulse is emitted.
- Worst-case acceptance latency: 2 + STABLE_TICKS*TICK_DIV cycles. Best case: 2 + (STABLE_TICKS-1)*TICK_DIV + 1.

Decomposition:
- Package debounce_pkg:
  - CLK_HZ = 100_000_000.
  - Default TICK_DIV/STABLE_TICKS constants.
  - Function cnt_width(n) returning $clog2(n+1).
- Sub-module debounce_channel: one channel with the sync pair, counter, level register and edge pulses. Inputs are clk, reset, tick and raw.
- Top input_debouncer owns the prescaler and a generate loop over N channels.

Test Plan (bench params N=3, TICK_DIV=4, STABLE_TICKS=3):
- Reset with raw_in=3'b000, release -> db_out=000, rise=fall=000 for all cycles, prescaler tick every 4th cycle.
- raw_in[0] 0->1 held steady -> db_out[0]=1 between 2+8+1 and 2+12 cycles after the change, rise[0]=1 for exactly one cycle, fall[0] never high.
- raw_in[1] pulses high for 6 cycles then low -> db_out[1] stays 0, no rise/fall, cnt returns to 0.
- Bounce on raw_in[2]: 1 for 5, 0 for 2, 1 for 5, 0 for 1, then held 1 -> single rise[2] only after 3 uninterrupted ticks of the final 1. Then drop to 0 and hold -> single fall[2].
- Channels 0 and 2 changed on the same cycle -> rise[0] and rise[2] on the same cycle, with channel 1 unaffected.
- Assert reset while channel 0 is at cnt=2 disagreeing -> db_out returns to 0 asynchronously with no pulse. After release, the held input is re-debounced from cnt=0 (full latency again).
